// File: rtl/stream_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : stream_rr_arb
//  Purpose  : Two-input packet arbiter that shares one valid/ready/last stream
//             consumer. It grants one whole packet at a time, round-robin under
//             contention, and drives a single registered output stage.
//  Revision : 1.0  initial release
// ============================================================================
module stream_rr_arb #(
    parameter int LEN   = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_0,
    input  logic [LEN-1:0]   data_0,
    input  logic             last_0,
    output logic             ready_0,
    input  logic             valid_1,
    input  logic [LEN-1:0]   data_1,
    input  logic             last_1,
    output logic             ready_1,
    output logic             valid,
    output logic [LEN-1:0]   data,
    output logic             last,
    input  logic             ready,
    output logic             grant,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt_0,
    output logic [CNT_W-1:0] pkt_cnt_1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [LEN-1:0]   data_q,  data_d;
    logic             last_q,  last_d;
    logic [CNT_W-1:0] cnt_0_q, cnt_0_d;
    logic [CNT_W-1:0] cnt_1_q, cnt_1_d;

    logic             w_out_free;
    logic             w_acc_0;
    logic             w_acc_1;

    // The output register can take a beat when empty or draining this cycle.
    assign w_out_free = ~valid_q | ready;
    assign ready_0    = (state_q == OWN0) & w_out_free;
    assign ready_1    = (state_q == OWN1) & w_out_free;
    assign w_acc_0    = valid_0 & ready_0;
    assign w_acc_1    = valid_1 & ready_1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_0_d = cnt_0_q;
        cnt_1_d = cnt_1_q;

        case (state_q)
            IDLE: begin
                // On a tie, input 0 wins when input 1 held the previous grant.
                if (valid_0 && (!valid_1 || grant_q)) begin
                    state_d = OWN0;
                    grant_d = 1'b0;
                end else if (valid_1) begin
                    state_d = OWN1;
                    grant_d = 1'b1;
                end
            end
            OWN0: begin
                if (w_acc_0 && last_0) begin
                    state_d = IDLE;
                    cnt_0_d = cnt_0_q + c_CNT_ONE;
                end
            end
            OWN1: begin
                if (w_acc_1 && last_1) begin
                    state_d = IDLE;
                    cnt_1_d = cnt_1_q + c_CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_acc_0) begin
            valid_d = 1'b1;
            data_d  = data_0;
            last_d  = last_0;
        end else if (w_acc_1) begin
            valid_d = 1'b1;
            data_d  = data_1;
            last_d  = last_1;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_0_q <= '0;
            cnt_1_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_0_q <= cnt_0_d;
            cnt_1_q <= cnt_1_d;
        end
    end

    assign valid     = valid_q;
    assign data      = data_q;
    assign last      = last_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign pkt_cnt_0 = cnt_0_q;
    assign pkt_cnt_1 = cnt_1_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_rr_arb
//  Purpose  : Self-checking bench for stream_rr_arb with queue-driven producers,
//             a packet-level reference model and directed plus random scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_rr_arb;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_0, last_0, ready_0, valid_1, last_1, ready_1;
    logic [7:0] data_0, data_1;
    logic       valid, last, ready, grant, busy;
    logic [7:0] data, pkt_cnt_0, pkt_cnt_1;
    logic       w2_ready_0, w2_ready_1, w2_valid, w2_last, w2_grant, w2_busy;
    logic [7:0] w2_data;
    logic [1:0] w2_cnt_0, w2_cnt_1;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t q0[$], q1[$], exp_q[$], log_q[$];
    int    log_cyc[$];
    bit    rand_ready = 1'b0;
    int    gap_pct    = 0;

    bit    m_busy, m_owner, m_last;
    int    m_cnt0, m_cnt1;
    bit    acc_seen, stall_seen;
    beat_t acc_beat, stall_beat;

    stream_rr_arb #(.LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .valid_0(valid_0), .data_0(data_0), .last_0(last_0), .ready_0(ready_0),
        .valid_1(valid_1), .data_1(data_1), .last_1(last_1), .ready_1(ready_1),
        .valid(valid), .data(data), .last(last), .ready(ready),
        .grant(grant), .busy(busy), .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
    );

    stream_rr_arb #(.LEN(8), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .valid_0(valid_0), .data_0(data_0), .last_0(last_0), .ready_0(w2_ready_0),
        .valid_1(valid_1), .data_1(data_1), .last_1(last_1), .ready_1(w2_ready_1),
        .valid(w2_valid), .data(w2_data), .last(w2_last), .ready(ready),
        .grant(w2_grant), .busy(w2_busy), .pkt_cnt_0(w2_cnt_0), .pkt_cnt_1(w2_cnt_1)
    );

    always #5 clk = ~clk;

    // Producers present the head of their queue and hold it until accepted.
    initial begin
        valid_0 = 1'b0; data_0 = '0; last_0 = 1'b0;
        valid_1 = 1'b0; data_1 = '0; last_1 = 1'b0;
        ready   = 1'b1;
        forever begin
            @(negedge clk);
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (q0.size() > 0 && (valid_0 || $urandom_range(0, 99) >= gap_pct)) begin
                valid_0 = 1'b1; data_0 = q0[0].d; last_0 = q0[0].l;
            end else begin
                valid_0 = 1'b0;
            end
            if (q1.size() > 0 && (valid_1 || $urandom_range(0, 99) >= gap_pct)) begin
                valid_1 = 1'b1; data_1 = q1[0].d; last_1 = q1[0].l;
            end else begin
                valid_1 = 1'b0;
            end
        end
    end

    // Edge monitor: handshakes, ownership rules and the output scoreboard.
    initial begin
        bit    a0, a1, idle_pre, w;
        beat_t e, b;
        forever begin
            @(posedge clk);
            cyc++;
            acc_seen   = 1'b0;
            stall_seen = 1'b0;
            if (!rst) begin
                a0 = valid_0 && ready_0;
                a1 = valid_1 && ready_1;
                idle_pre = !m_busy;
                checks++;
                if ((idle_pre && (ready_0 || ready_1 || w2_ready_0 || w2_ready_1)) ||
                    (!idle_pre && (m_owner ? ready_0 : ready_1))) begin
                    errors++;
                    $display("FAIL ready_owner: got r0=%b r1=%b busy_model=%b owner_model=%0d",
                             ready_0, ready_1, m_busy, m_owner);
                end
                if (valid && ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_extra: got beat %h expected no beat", {data, last});
                    end else begin
                        e = exp_q.pop_front();
                        if ({data, last} !== e) begin
                            errors++;
                            $display("FAIL out_data: got %h expected %h", {data, last}, e);
                        end
                    end
                    log_q.push_back({data, last});
                    log_cyc.push_back(cyc);
                end
                if (valid && !ready) begin
                    stall_seen = 1'b1;
                    stall_beat = {data, last};
                end
                if (a0 || a1) begin
                    checks++;
                    if ((a0 && a1) || idle_pre || (m_owner != a1)) begin
                        errors++;
                        $display("FAIL accept_owner: got a0=%b a1=%b expected owner %0d busy %b",
                                 a0, a1, m_owner, m_busy);
                    end
                    b = a0 ? {data_0, last_0} : {data_1, last_1};
                    exp_q.push_back(b);
                    acc_seen = 1'b1;
                    acc_beat = b;
                    if (a0) void'(q0.pop_front());
                    else    void'(q1.pop_front());
                    if (!idle_pre && b.l) begin
                        m_busy = 1'b0;
                        if (a0) m_cnt0++;
                        else    m_cnt1++;
                    end
                end
                // Arbitration happens in the cycle the arbiter sits idle.
                if (idle_pre && (valid_0 || valid_1)) begin
                    w = (valid_0 && valid_1) ? !m_last : valid_1;
                    m_busy  = 1'b1;
                    m_owner = w;
                    m_last  = w;
                end
            end
        end
    end

    // Mid-cycle checks of the registered outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (busy !== m_busy || w2_busy !== m_busy) begin
                    errors++;
                    $display("FAIL busy: got %b/%b expected %b", busy, w2_busy, m_busy);
                end
                checks++;
                if (grant !== m_last || w2_grant !== m_last) begin
                    errors++;
                    $display("FAIL grant: got %b/%b expected %b", grant, w2_grant, m_last);
                end
                checks++;
                if (pkt_cnt_0 !== m_cnt0[7:0] || pkt_cnt_1 !== m_cnt1[7:0] ||
                    w2_cnt_0 !== m_cnt0[1:0] || w2_cnt_1 !== m_cnt1[1:0]) begin
                    errors++;
                    $display("FAIL pkt_cnt: got %0d/%0d w2 %0d/%0d expected %0d/%0d",
                             pkt_cnt_0, pkt_cnt_1, w2_cnt_0, w2_cnt_1, m_cnt0, m_cnt1);
                end
                if (acc_seen) begin
                    checks++;
                    if (valid !== 1'b1 || {data, last} !== acc_beat ||
                        w2_valid !== 1'b1 || {w2_data, w2_last} !== acc_beat) begin
                        errors++;
                        $display("FAIL latency: got v=%b beat=%h expected v=1 beat=%h",
                                 valid, {data, last}, acc_beat);
                    end
                end else if (stall_seen) begin
                    checks++;
                    if (valid !== 1'b1 || {data, last} !== stall_beat) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b beat=%h expected v=1 beat=%h",
                                 valid, {data, last}, stall_beat);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic model_clear();
        q0.delete(); q1.delete(); exp_q.delete();
        m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1;
        m_cnt0 = 0; m_cnt1 = 0;
        acc_seen = 1'b0; stall_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_q.delete(); log_cyc.delete();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_drain: got timeout with %0d beats pending expected empty",
                     name, q0.size() + q1.size() + exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || data !== 8'h00 || last !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got v=%b d=%h l=%b expected 0/00/0", valid, data, last);
        end
        checks++;
        if (busy !== 1'b0 || grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got busy=%b grant=%b expected 0/1", busy, grant);
        end
        checks++;
        if (pkt_cnt_0 !== 8'd0 || pkt_cnt_1 !== 8'd0 || ready_0 !== 1'b0 || ready_1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt_ready: got %0d %0d r=%b%b expected 0 0 r=00",
                     pkt_cnt_0, pkt_cnt_1, ready_0, ready_1);
        end
        do_reset();
    endtask

    task automatic test_single_input();
        logic [7:0] exp_d [3];
        do_reset();
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        q0.push_back({8'h11, 1'b0}); q0.push_back({8'h22, 1'b0}); q0.push_back({8'h33, 1'b1});
        wait_drain("single");
        checks++;
        if (log_q.size() != 3) begin
            errors++;
            $display("FAIL single_count: got %0d beats expected 3", log_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_q[i] !== {exp_d[i], (i == 2)} || log_cyc[i] != log_cyc[0] + i) begin
                    errors++;
                    $display("FAIL single_beat%0d: got %h at +%0d expected %h at +%0d",
                             i, log_q[i], log_cyc[i] - log_cyc[0], {exp_d[i], (i == 2)}, i);
                end
            end
        end
        checks++;
        if (pkt_cnt_0 !== 8'd1 || grant !== 1'b0) begin
            errors++;
            $display("FAIL single_final: got cnt0=%0d grant=%b expected 1/0", pkt_cnt_0, grant);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_d [4];
        do_reset();
        exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hB0; exp_d[3] = 8'hB1;
        q0.push_back({8'hA0, 1'b0}); q0.push_back({8'hA1, 1'b1});
        q1.push_back({8'hB0, 1'b0}); q1.push_back({8'hB1, 1'b1});
        wait_drain("contention");
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("FAIL contention_count: got %0d beats expected 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_q[i].d !== exp_d[i]) begin
                    errors++;
                    $display("FAIL contention_order%0d: got %h expected %h", i, log_q[i].d, exp_d[i]);
                end
            end
            checks++;
            if (log_cyc[2] - log_cyc[1] != 2) begin
                errors++;
                $display("FAIL contention_gap: got %0d cycles expected 2", log_cyc[2] - log_cyc[1]);
            end
        end
        checks++;
        if (pkt_cnt_0 !== 8'd1 || pkt_cnt_1 !== 8'd1) begin
            errors++;
            $display("FAIL contention_cnt: got %0d/%0d expected 1/1", pkt_cnt_0, pkt_cnt_1);
        end
    endtask

    task automatic test_alternation();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back({8'(8'h00 + i), 1'b1});
            q1.push_back({8'(8'h80 + i), 1'b1});
        end
        wait_drain("alternation");
        checks++;
        if (log_q.size() != 8) begin
            errors++;
            $display("FAIL alt_count: got %0d beats expected 8", log_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_q[i].d !== 8'((i % 2) * 128 + i / 2)) begin
                    errors++;
                    $display("FAIL alt_order%0d: got %h expected %h", i, log_q[i].d, 8'((i % 2) * 128 + i / 2));
                end
            end
        end
        checks++;
        if (pkt_cnt_0 !== 8'd4 || pkt_cnt_1 !== 8'd4) begin
            errors++;
            $display("FAIL alt_cnt: got %0d/%0d expected 4/4", pkt_cnt_0, pkt_cnt_1);
        end
    endtask

    task automatic test_stall();
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 4; i++) q1.push_back({8'(8'hC0 + i), (i == 3)});
        wait_drain("stall");
        rand_ready = 1'b0;
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats expected 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_q[i] !== {8'(8'hC0 + i), (i == 3)}) begin
                    errors++;
                    $display("FAIL stall_seq%0d: got %h expected %h", i, log_q[i], {8'(8'hC0 + i), (i == 3)});
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            q0.push_back({8'(8'h60 + 2 * p), 1'b0});
            q0.push_back({8'(8'h61 + 2 * p), 1'b1});
        end
        wait_drain("wrap");
        checks++;
        if (w2_cnt_0 !== 2'd1 || pkt_cnt_0 !== 8'd5) begin
            errors++;
            $display("FAIL wrap_cnt: got w2=%0d wide=%0d expected 1/5", w2_cnt_0, pkt_cnt_0);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        for (int i = 0; i < 4; i++) q0.push_back({8'(8'h40 + i), (i == 3)});
        while (q0.size() > 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data !== 8'h00 || last !== 1'b0 || grant !== 1'b1) begin
            errors++;
            $display("FAIL midrst_now: got v=%b busy=%b d=%h l=%b g=%b expected 0/0/00/0/1",
                     valid, busy, data, last, grant);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_q.delete(); log_cyc.delete();
        q0.push_back({8'h50, 1'b1});
        q1.push_back({8'hD0, 1'b1});
        wait_drain("midrst");
        checks++;
        if (log_q.size() != 2 || log_q[0].d !== 8'h50 || log_q[1].d !== 8'hD0) begin
            errors++;
            $display("FAIL midrst_tie: got %0d beats first %h expected 2 beats first 50",
                     log_q.size(), (log_q.size() > 0) ? log_q[0].d : 8'hxx);
        end
    endtask

    task automatic test_random();
        int n0 = 0, n1 = 0, seq = 0, len;
        bit src;
        do_reset();
        rand_ready = 1'b1;
        gap_pct    = 40;
        for (int p = 0; p < 30; p++) begin
            src = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                if (src) q1.push_back({1'b1, 7'(seq), (k == len - 1)});
                else     q0.push_back({1'b0, 7'(seq), (k == len - 1)});
                seq++;
            end
            if (src) n1++;
            else     n0++;
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_drain("random");
        rand_ready = 1'b0;
        gap_pct    = 0;
        checks++;
        if (pkt_cnt_0 !== 8'(n0) || pkt_cnt_1 !== 8'(n1) || log_q.size() != seq) begin
            errors++;
            $display("FAIL random_totals: got %0d/%0d pkts %0d beats expected %0d/%0d pkts %0d beats",
                     pkt_cnt_0, pkt_cnt_1, log_q.size(), n0, n1, seq);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_input();
        test_contention();
        test_alternation();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
